// File: rtl/mips_ni_bridge.sv
// Network interface bridge between a MIPS core and a NoC router.
// Outgoing words are queued as flits; incoming flits and local loopback words feed an RX queue.
module mips_ni_bridge #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEST_W      = 2,
  parameter int unsigned NODE_ID     = 0,
  parameter int unsigned TX_DEPTH    = 4,
  parameter int unsigned RX_DEPTH    = 4,
  parameter bit          LOOPBACK_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         proc_valid,
  input  logic [DEST_W-1:0]            dest_add,
  input  logic [DATA_W-1:0]            proc_data,
  output logic                         proc_ready_out,
  input  logic                         proc_ready_in,
  output logic                         data_valid,
  output logic [DATA_W-1:0]            wd_NI,
  output logic                         net_tx_valid,
  input  logic                         net_tx_ready,
  output logic [2*DEST_W+DATA_W-1:0]   net_tx_flit,
  input  logic                         net_rx_valid,
  output logic                         net_rx_ready,
  input  logic [2*DEST_W+DATA_W-1:0]   net_rx_flit,
  output logic                         err_misroute,
  output logic [15:0]                  tx_cnt,
  output logic [15:0]                  rx_cnt
);

  localparam int unsigned FW    = 2*DEST_W + DATA_W;
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam logic [DEST_W-1:0] NODE   = DEST_W'(NODE_ID);
  localparam logic [TX_AW:0]    TX_ONE = (TX_AW+1)'(1);
  localparam logic [RX_AW:0]    RX_ONE = (RX_AW+1)'(1);

  logic [FW-1:0]     tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW:0]    tx_wr, tx_rd;
  logic [RX_AW:0]    rx_wr, rx_rd;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic is_loop, rx_local;
  logic proc_fire, tx_push, tx_pop;
  logic net_fire, rx_push_net, rx_push_loop, rx_push, rx_pop;
  logic [DEST_W-1:0] rx_dest;
  logic [DATA_W-1:0] rx_din;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign tx_full  = (tx_wr[TX_AW] != tx_rd[TX_AW]) && (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign rx_full  = (rx_wr[RX_AW] != rx_rd[RX_AW]) && (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]);
  assign rx_empty = (rx_wr == rx_rd);

  assign rx_dest  = net_rx_flit[FW-1 -: DEST_W];
  assign rx_local = (rx_dest == NODE);
  assign is_loop  = LOOPBACK_EN && (dest_add == NODE);

  assign net_rx_ready   = !rx_full;
  assign net_tx_valid   = !tx_empty;
  assign net_tx_flit    = tx_mem[tx_rd[TX_AW-1:0]];
  assign data_valid     = !rx_empty;
  assign wd_NI          = rx_mem[rx_rd[RX_AW-1:0]];

  // A network flit arriving this cycle owns the RX write port, so loopback yields.
  assign proc_ready_out = is_loop ? (!rx_full && !(net_rx_valid && net_rx_ready)) : !tx_full;

  assign proc_fire    = proc_valid && proc_ready_out && !rst;
  assign tx_push      = proc_fire && !is_loop;
  assign tx_pop       = net_tx_valid && net_tx_ready && !rst;
  assign net_fire     = net_rx_valid && net_rx_ready && !rst;
  assign rx_push_net  = net_fire && rx_local;
  assign rx_push_loop = proc_fire && is_loop;
  assign rx_push      = rx_push_net || rx_push_loop;
  assign rx_pop       = data_valid && proc_ready_in && !rst;
  assign rx_din       = rx_push_net ? net_rx_flit[DATA_W-1:0] : proc_data;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[TX_AW-1:0]] <= {dest_add, NODE, proc_data};
    if (rx_push) rx_mem[rx_wr[RX_AW-1:0]] <= rx_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr        <= '0;
      tx_rd        <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      err_misroute <= 1'b0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_ONE;
      if (tx_pop) begin
        tx_rd  <= tx_rd + TX_ONE;
        tx_cnt <= tx_cnt + 16'd1;
      end
      if (rx_push) rx_wr <= rx_wr + RX_ONE;
      if (rx_pop) begin
        rx_rd  <= rx_rd + RX_ONE;
        rx_cnt <= rx_cnt + 16'd1;
      end
      if (net_fire && !rx_local) err_misroute <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_ni_bridge.sv
// Self-checking bench for mips_ni_bridge: directed vector table, reset sequence,
// randomized run against a queue-based reference model, and a wide/deep configuration.
module tb_mips_ni_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pv, pro, pri, dv, txv, txr, rxv, rxr, err;
  logic [1:0]  dest;
  logic [31:0] pdata, wd;
  logic [35:0] txf, rxf;
  logic [15:0] txc, rxc;

  logic        pv2, pro2, pri2, dv2, txv2, txr2, rxv2, rxr2, err2;
  logic [3:0]  dest2;
  logic [63:0] pdata2, wd2;
  logic [71:0] txf2, rxf2;
  logic [15:0] txc2, rxc2;

  mips_ni_bridge dut (
    .clk(clk), .rst(rst), .proc_valid(pv), .dest_add(dest), .proc_data(pdata),
    .proc_ready_out(pro), .proc_ready_in(pri), .data_valid(dv), .wd_NI(wd),
    .net_tx_valid(txv), .net_tx_ready(txr), .net_tx_flit(txf),
    .net_rx_valid(rxv), .net_rx_ready(rxr), .net_rx_flit(rxf),
    .err_misroute(err), .tx_cnt(txc), .rx_cnt(rxc)
  );

  mips_ni_bridge #(.DATA_W(64), .DEST_W(4), .NODE_ID(0), .TX_DEPTH(8), .RX_DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .proc_valid(pv2), .dest_add(dest2), .proc_data(pdata2),
    .proc_ready_out(pro2), .proc_ready_in(pri2), .data_valid(dv2), .wd_NI(wd2),
    .net_tx_valid(txv2), .net_tx_ready(txr2), .net_tx_flit(txf2),
    .net_rx_valid(rxv2), .net_rx_ready(rxr2), .net_rx_flit(rxf2),
    .err_misroute(err2), .tx_cnt(txc2), .rx_cnt(rxc2)
  );

  typedef struct {
    logic pv; logic [1:0] dest; logic [31:0] data; logic txr; logic rxv; logic [35:0] rxf; logic pri;
    logic e_pro; logic e_txv; logic [35:0] e_txf; logic e_dv; logic [31:0] e_wd;
    logic e_rxr; logic e_err; logic [15:0] e_txc; logic [15:0] e_rxc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  logic [35:0] mtx[$];
  logic [31:0] mrx[$];
  int          mtxc, mrxc;
  logic        merr;
  logic [63:0] exp2 [8];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pv = v.pv; dest = v.dest; pdata = v.data; txr = v.txr;
    rxv = v.rxv; rxf = v.rxf; pri = v.pri;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] fl(input logic [1:0] d, input logic [1:0] s, input logic [31:0] x);
    return {d, s, x};
  endfunction

  function automatic vec_t row(input logic pv_i, input logic [1:0] d, input logic [31:0] x,
                               input logic tr, input logic rv, input logic [35:0] rf, input logic pr,
                               input logic epro, input logic etxv, input logic [35:0] etxf,
                               input logic edv, input logic [31:0] ewd, input logic erxr,
                               input logic eerr, input logic [15:0] etxc, input logic [15:0] erxc);
    vec_t v;
    v.pv = pv_i; v.dest = d; v.data = x; v.txr = tr; v.rxv = rv; v.rxf = rf; v.pri = pr;
    v.e_pro = epro; v.e_txv = etxv; v.e_txf = etxf; v.e_dv = edv; v.e_wd = ewd;
    v.e_rxr = erxr; v.e_err = eerr; v.e_txc = etxc; v.e_rxc = erxc;
    return v;
  endfunction

  task automatic idleAll();
    pv = 0; dest = 0; pdata = 0; txr = 0; rxv = 0; rxf = 0; pri = 0;
    pv2 = 0; dest2 = 0; pdata2 = 0; txr2 = 0; rxv2 = 0; rxf2 = 0; pri2 = 0;
  endtask

  initial begin
    logic [31:0] D1, D2, D3, D4, D5, E1, E2, E3, E4, E5, N1, L1, X1;
    logic [31:0] DB;
    D1 = 32'h1000_0001; D2 = 32'h1000_0002; D3 = 32'h1000_0003; D4 = 32'h1000_0004; D5 = 32'h1000_0005;
    E1 = 32'h2000_0001; E2 = 32'h2000_0002; E3 = 32'h2000_0003; E4 = 32'h2000_0004; E5 = 32'h2000_0005;
    N1 = 32'h3000_0001; L1 = 32'h4000_0001; X1 = 32'h5000_0001; DB = 32'hDEAD_BEEF;

    // Fill up TX with dest 2, overflow attempt, drain; full+pop+push corner; loopback; RX priority; misroute.
    tbl.push_back(row(0,0,0 ,0,0,0,0, 1,0,0,0,0,1,0,0,0));
    tbl.push_back(row(1,2,D1,0,0,0,0, 1,0,0,0,0,1,0,0,0));
    tbl.push_back(row(1,2,D2,0,0,0,0, 1,1,fl(2,0,D1),0,0,1,0,0,0));
    tbl.push_back(row(1,2,D3,0,0,0,0, 1,1,fl(2,0,D1),0,0,1,0,0,0));
    tbl.push_back(row(1,2,D4,0,0,0,0, 1,1,fl(2,0,D1),0,0,1,0,0,0));
    tbl.push_back(row(1,2,D5,0,0,0,0, 0,1,fl(2,0,D1),0,0,1,0,0,0));
    tbl.push_back(row(0,2,0 ,1,0,0,0, 0,1,fl(2,0,D1),0,0,1,0,0,0));
    tbl.push_back(row(0,2,0 ,1,0,0,0, 1,1,fl(2,0,D2),0,0,1,0,1,0));
    tbl.push_back(row(0,2,0 ,1,0,0,0, 1,1,fl(2,0,D3),0,0,1,0,2,0));
    tbl.push_back(row(0,2,0 ,1,0,0,0, 1,1,fl(2,0,D4),0,0,1,0,3,0));
    tbl.push_back(row(0,2,0 ,1,0,0,0, 1,0,0,0,0,1,0,4,0));
    tbl.push_back(row(1,1,E1,0,0,0,0, 1,0,0,0,0,1,0,4,0));
    tbl.push_back(row(1,1,E2,0,0,0,0, 1,1,fl(1,0,E1),0,0,1,0,4,0));
    tbl.push_back(row(1,1,E3,0,0,0,0, 1,1,fl(1,0,E1),0,0,1,0,4,0));
    tbl.push_back(row(1,1,E4,0,0,0,0, 1,1,fl(1,0,E1),0,0,1,0,4,0));
    tbl.push_back(row(1,1,E5,1,0,0,0, 0,1,fl(1,0,E1),0,0,1,0,4,0));
    tbl.push_back(row(1,1,E5,0,0,0,0, 1,1,fl(1,0,E2),0,0,1,0,5,0));
    tbl.push_back(row(0,1,0 ,1,0,0,0, 0,1,fl(1,0,E2),0,0,1,0,5,0));
    tbl.push_back(row(0,1,0 ,1,0,0,0, 1,1,fl(1,0,E3),0,0,1,0,6,0));
    tbl.push_back(row(0,1,0 ,1,0,0,0, 1,1,fl(1,0,E4),0,0,1,0,7,0));
    tbl.push_back(row(0,1,0 ,1,0,0,0, 1,1,fl(1,0,E5),0,0,1,0,8,0));
    tbl.push_back(row(1,0,DB,0,0,0,0, 1,0,0,0,0,1,0,9,0));
    tbl.push_back(row(0,0,0 ,0,0,0,1, 1,0,0,1,DB,1,0,9,0));
    tbl.push_back(row(1,0,L1,0,1,fl(0,3,N1),0, 0,0,0,0,0,1,0,9,1));
    tbl.push_back(row(1,0,L1,0,0,0,0, 1,0,0,1,N1,1,0,9,1));
    tbl.push_back(row(0,0,0 ,0,0,0,1, 1,0,0,1,N1,1,0,9,1));
    tbl.push_back(row(0,0,0 ,0,0,0,1, 1,0,0,1,L1,1,0,9,2));
    tbl.push_back(row(0,2,0 ,0,1,fl(3,1,X1),0, 1,0,0,0,0,1,0,9,3));
    tbl.push_back(row(0,2,0 ,0,0,0,0, 1,0,0,0,0,1,1,9,3));
    tbl.push_back(row(0,2,0 ,0,0,0,0, 1,0,0,0,0,1,1,9,3));

    idleAll();
    rst = 1'b1;
    tick(); tick();
    checkOutput("rst.txv", txv, 0);
    checkOutput("rst.dv", dv, 0);
    checkOutput("rst.rxr", rxr, 1);
    checkOutput("rst.pro", pro, 1);
    checkOutput("rst.err", err, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("v%0d.pro", i), pro, tbl[i].e_pro);
      checkOutput($sformatf("v%0d.txv", i), txv, tbl[i].e_txv);
      if (tbl[i].e_txv) checkOutput($sformatf("v%0d.txf", i), txf, tbl[i].e_txf);
      checkOutput($sformatf("v%0d.dv", i), dv, tbl[i].e_dv);
      if (tbl[i].e_dv) checkOutput($sformatf("v%0d.wd", i), wd, tbl[i].e_wd);
      checkOutput($sformatf("v%0d.rxr", i), rxr, tbl[i].e_rxr);
      checkOutput($sformatf("v%0d.err", i), err, tbl[i].e_err);
      checkOutput($sformatf("v%0d.txc", i), txc, tbl[i].e_txc);
      checkOutput($sformatf("v%0d.rxc", i), rxc, tbl[i].e_rxc);
      tick();
    end

    // Reset with partially filled FIFOs; proc_valid held high through reset must not push.
    idleAll();
    for (int i = 0; i < 3; i++) begin
      pv = 1; dest = 2; pdata = 32'h7000_0000 + 32'(i);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      pv = 1; dest = 0; pdata = 32'h7100_0000 + 32'(i);
      tick();
    end
    pv = 0;
    #1;
    checkOutput("pre.txv", txv, 1);
    checkOutput("pre.dv", dv, 1);
    rst = 1; pv = 1; dest = 2;
    tick();
    checkOutput("rst2.txv", txv, 0);
    checkOutput("rst2.dv", dv, 0);
    checkOutput("rst2.txc", txc, 0);
    checkOutput("rst2.rxc", rxc, 0);
    checkOutput("rst2.err", err, 0);
    checkOutput("rst2.rxr", rxr, 1);
    checkOutput("rst2.pro", pro, 1);
    tick();
    checkOutput("rst3.txv", txv, 0);
    rst = 0; pv = 0;
    tick();
    checkOutput("post.txv", txv, 0);
    checkOutput("post.dv", dv, 0);

    // Randomized run against a queue model of both FIFOs.
    mtx.delete(); mrx.delete(); mtxc = 0; mrxc = 0; merr = 0;
    for (int c = 0; c < 600; c++) begin
      logic m_pro, m_rxr, loop_m, m_acc;
      pv    = 1'($urandom_range(0, 1));
      dest  = 2'($urandom_range(0, 3));
      pdata = $urandom;
      txr   = ($urandom_range(0, 2) == 0);
      rxv   = ($urandom_range(0, 2) == 0);
      rxf   = fl(($urandom_range(0, 15) == 0) ? 2'd3 : 2'd0, 2'($urandom_range(0, 3)), $urandom);
      pri   = ($urandom_range(0, 2) != 0);
      #1;
      m_rxr  = (mrx.size() < 4);
      loop_m = (dest == 2'd0);
      m_pro  = loop_m ? (m_rxr && !(rxv && m_rxr)) : (mtx.size() < 4);
      checkOutput("rnd.pro", pro, m_pro);
      checkOutput("rnd.rxr", rxr, m_rxr);
      checkOutput("rnd.txv", txv, mtx.size() > 0);
      if (mtx.size() > 0) checkOutput("rnd.txf", txf, mtx[0]);
      checkOutput("rnd.dv", dv, mrx.size() > 0);
      if (mrx.size() > 0) checkOutput("rnd.wd", wd, mrx[0]);
      checkOutput("rnd.err", err, merr);
      checkOutput("rnd.txc", txc, 16'(mtxc));
      checkOutput("rnd.rxc", rxc, 16'(mrxc));
      m_acc = pv && m_pro;
      if (mtx.size() > 0 && txr) begin void'(mtx.pop_front()); mtxc++; end
      if (m_acc && !loop_m) mtx.push_back(fl(dest, 2'd0, pdata));
      if (mrx.size() > 0 && pri) begin void'(mrx.pop_front()); mrxc++; end
      if (rxv && m_rxr) begin
        if (rxf[35:34] == 2'd0) mrx.push_back(rxf[31:0]);
        else merr = 1;
      end else if (m_acc && loop_m) begin
        mrx.push_back(pdata);
      end
      tick();
    end

    // Wide configuration: 64-bit data, 4-bit addresses, 8-deep FIFOs.
    idleAll();
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp2[i] = {32'hCAFE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i)};
      pv2 = 1; dest2 = 4'd2; pdata2 = {32'hCAFE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i)};
      #1;
      checkOutput($sformatf("w.pro%0d", i), pro2, (i < 8));
      tick();
    end
    pv2 = 0; txr2 = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("w.txv%0d", i), txv2, 1);
      checkOutput($sformatf("w.txf%0d", i), txf2, {4'd2, 4'd0, exp2[i]});
      tick();
    end
    #1;
    checkOutput("w.txv_end", txv2, 0);
    checkOutput("w.txc", txc2, 16'd8);
    txr2 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
